// File: rtl/tt_mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_mux_pkg : select-word field map, FSM state type, index width  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tt_mux_pkg;

  localparam int SEL_ROW_HI = 9;
  localparam int SEL_ROW_LO = 6;
  localparam int SEL_LSB    = 5;
  localparam int SEL_BANK   = 4;
  localparam int SEL_COL_HI = 3;
  localparam int SEL_COL_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_GUARD = 2'd2,
    ST_MAKE  = 2'd3
  } mux_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_mux_ow_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_mux_ow_pipe : DEPTH-stage data+valid register chain           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tt_mux_ow_pipe #(
  parameter int W     = 24,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic [W-1:0] out_data,
  output logic         out_vld
);

  generate
    if (DEPTH == 0) begin : g_comb
      assign out_data = in_data;
      assign out_vld  = in_vld;
    end else begin : g_regs
      logic [W:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
          stage[0] <= {in_vld, in_data};
          for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
      end

      assign {out_vld, out_data} = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/tt_mux_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tt_mux_sync : clocked row mux, strobe-latched break-before-make  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tt_mux_sync
  import tt_mux_pkg::*;
#(
  parameter int N_UM      = 8,
  parameter int N_IO      = 8,
  parameter int N_O       = 8,
  parameter int N_I       = 10,
  parameter int GUARD_CYC = 2,
  parameter int OW_PIPE   = 1,
  parameter int U_OW      = N_O + 2 * N_IO,
  parameter int U_IW      = N_I + N_IO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           addr,
  input  logic [9:0]           spine_sel,
  input  logic                 spine_sel_stb,
  input  logic                 spine_ena,
  input  logic [U_IW-1:0]      spine_usr_iw,
  output logic [U_OW-1:0]      spine_usr_ow,
  output logic                 spine_ow_vld,
  output logic                 busy,
  input  logic [U_OW*N_UM-1:0] um_ow,
  output logic [U_IW*N_UM-1:0] um_iw,
  output logic [N_UM-1:0]      um_ena
);

  localparam int         IDX_W   = idx_width(N_UM);
  localparam logic [5:0] N_UM_L  = 6'(N_UM);
  localparam logic [3:0] GUARD_L = 4'(GUARD_CYC);

  mux_state_t       state, state_nxt;
  logic [9:0]       pend_sel;
  logic             redo;
  logic [3:0]       guard_cnt;
  logic             cur_vld;
  logic [IDX_W-1:0] cur_idx;
  logic             active;
  logic             row_hit;
  logic [4:0]       dec_idx;
  logic             dec_vld;
  logic [U_OW-1:0]  ow_sel;

  assign row_hit = (pend_sel[SEL_ROW_HI:SEL_ROW_LO] == addr[4:1]) &&
                   (pend_sel[SEL_BANK] == addr[0]);
  assign dec_idx = {pend_sel[SEL_COL_HI:SEL_COL_LO], pend_sel[SEL_LSB]};
  assign dec_vld = row_hit && ({1'b0, dec_idx} < N_UM_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A strobe landing in MAKE restarts directly, same as a latched redo.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (spine_sel_stb) state_nxt = ST_BREAK;
      ST_BREAK: state_nxt = (GUARD_CYC == 0) ? ST_MAKE : ST_GUARD;
      ST_GUARD: if (guard_cnt == GUARD_L) state_nxt = ST_MAKE;
      ST_MAKE:  state_nxt = (redo || spine_sel_stb) ? ST_BREAK : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    active = cur_vld && (state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_sel  <= '0;
      redo      <= 1'b0;
      guard_cnt <= '0;
      cur_vld   <= 1'b0;
      cur_idx   <= '0;
    end else begin
      if (spine_sel_stb) pend_sel <= spine_sel;
      redo <= ((state == ST_BREAK) || (state == ST_GUARD)) ? (redo | spine_sel_stb) : 1'b0;
      if (state == ST_BREAK) begin
        cur_vld   <= 1'b0;
        guard_cnt <= '0;
      end
      if (state == ST_GUARD) guard_cnt <= guard_cnt + 4'd1;
      if (state == ST_MAKE) begin
        cur_vld <= dec_vld;
        cur_idx <= dec_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ow_sel = '0;
    for (int i = 0; i < N_UM; i++) begin
      if (active && (cur_idx == IDX_W'(i))) ow_sel = um_ow[U_OW*i +: U_OW];
    end
  end

  generate
    for (genvar g = 0; g < N_UM; g++) begin : g_um
      logic hit;
      assign hit                   = active && (cur_idx == IDX_W'(g));
      assign um_iw[U_IW*g +: U_IW] = hit ? spine_usr_iw : '0;
      assign um_ena[g]             = hit && spine_ena;
    end
  endgenerate

  tt_mux_ow_pipe #(
    .W     (U_OW),
    .DEPTH (OW_PIPE)
  ) u_ow_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (ow_sel),
    .in_vld   (active),
    .out_data (spine_usr_ow),
    .out_vld  (spine_ow_vld)
  );

endmodule
`default_nettype wire

// File: tb/tb_tt_mux_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tt_mux_sync : directed self-checking bench for tt_mux_sync    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tt_mux_sync;

  localparam int N_UM = 8;
  localparam int N6   = 6;
  localparam int U_OW = 24;
  localparam int U_IW = 18;
  localparam logic [U_IW-1:0] IW_VAL = 18'h2B3C5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [4:0]           addr;
  logic [9:0]           spine_sel, spine_sel6;
  logic                 spine_sel_stb, spine_sel_stb6;
  logic                 spine_ena;
  logic [U_IW-1:0]      spine_usr_iw;
  logic [U_OW-1:0]      spine_usr_ow, spine_usr_ow6;
  logic                 spine_ow_vld, spine_ow_vld6;
  logic                 busy, busy6;
  logic [U_OW*N_UM-1:0] um_ow;
  logic [U_IW*N_UM-1:0] um_iw;
  logic [N_UM-1:0]      um_ena;
  logic [U_OW*N6-1:0]   um_ow6;
  logic [U_IW*N6-1:0]   um_iw6;
  logic [N6-1:0]        um_ena6;

  int n_tests = 0;
  int n_fail  = 0;
  int nb;
  logic [7:0] ena_or;
  logic stale;
  logic busy_seen;

  always #5 clk = ~clk;

  tt_mux_sync #(.N_UM(N_UM)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .spine_sel(spine_sel), .spine_sel_stb(spine_sel_stb), .spine_ena(spine_ena),
    .spine_usr_iw(spine_usr_iw), .spine_usr_ow(spine_usr_ow), .spine_ow_vld(spine_ow_vld),
    .busy(busy), .um_ow(um_ow), .um_iw(um_iw), .um_ena(um_ena)
  );

  tt_mux_sync #(.N_UM(N6)) dut6 (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .spine_sel(spine_sel6), .spine_sel_stb(spine_sel_stb6), .spine_ena(spine_ena),
    .spine_usr_iw(spine_usr_iw), .spine_usr_ow(spine_usr_ow6), .spine_ow_vld(spine_ow_vld6),
    .busy(busy6), .um_ow(um_ow6), .um_iw(um_iw6), .um_ena(um_ena6)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // select word layout: {row[3:0], idx[0], bank, idx[4:1]}
  function automatic logic [9:0] mk_sel(input logic [3:0] row, input logic bank, input logic [4:0] idx);
    return {row, idx[0], bank, idx[4:1]};
  endfunction

  function automatic logic [U_IW*N_UM-1:0] iw_at(input int idx);
    logic [U_IW*N_UM-1:0] v;
    v = '0;
    v[U_IW*idx +: U_IW] = IW_VAL;
    return v;
  endfunction

  task automatic pulse(input logic [9:0] s);
    spine_sel     = s;
    spine_sel_stb = 1'b1;
    @(negedge clk);
    spine_sel_stb = 1'b0;
  endtask

  // Counts busy cycles from the current sample point; data valid is allowed
  // only in the first (pipeline-lag) cycle of the sequence.
  task automatic wait_idle(output int n, output logic [7:0] eo, output logic st);
    n  = 0;
    eo = '0;
    st = 1'b0;
    while (busy && n < 64) begin
      eo |= um_ena;
      if (n >= 1 && spine_ow_vld) st = 1'b1;
      n++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    addr           = 5'h03;
    spine_sel      = '0;
    spine_sel6     = '0;
    spine_sel_stb  = 1'b0;
    spine_sel_stb6 = 1'b0;
    spine_ena      = 1'b1;
    spine_usr_iw   = IW_VAL;
    um_ow          = '0;
    um_ow[U_OW*5 +: U_OW] = 24'hA5A5A5;
    um_ow[U_OW*2 +: U_OW] = 24'h5A5A5A;
    um_ow[U_OW*3 +: U_OW] = 24'h3C3C3C;
    um_ow[U_OW*6 +: U_OW] = 24'hC3C3C3;
    um_ow[U_OW*1 +: U_OW] = 24'h111111;
    um_ow6         = {N6{24'h777777}};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ena", um_ena, 8'h00);
    check("rst_iw", um_iw, '0);
    check("rst_ow", spine_usr_ow, '0);
    check("rst_vld", spine_ow_vld, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // select index 5 in row 1 / bank 1 (addr 5'h03)
    pulse(mk_sel(4'h1, 1'b1, 5'd5));
    wait_idle(nb, ena_or, stale);
    check("t1_busy_cycles", nb, 5);
    check("t1_ena_during", ena_or, 8'h00);
    check("t1_ena", um_ena, 8'h20);
    check("t1_iw", um_iw, iw_at(5));
    check("t1_vld_lag", spine_ow_vld, 1'b0);
    @(negedge clk);
    check("t1_ow", spine_usr_ow, 24'hA5A5A5);
    check("t1_vld", spine_ow_vld, 1'b1);

    // switch 5 -> 2: enable must pass through all-zero, no stale data
    pulse(mk_sel(4'h1, 1'b1, 5'd2));
    wait_idle(nb, ena_or, stale);
    check("t2_busy_cycles", nb, 5);
    check("t2_ena_gap", ena_or, 8'h00);
    check("t2_stale_vld", stale, 1'b0);
    check("t2_ena", um_ena, 8'h04);
    @(negedge clk);
    check("t2_ow", spine_usr_ow, 24'h5A5A5A);
    check("t2_vld", spine_ow_vld, 1'b1);

    // strobe 3, then 6 during GUARD: one redo, 3 never enabled
    pulse(mk_sel(4'h1, 1'b1, 5'd3));
    @(negedge clk);
    pulse(mk_sel(4'h1, 1'b1, 5'd6));
    wait_idle(nb, ena_or, stale);
    check("t3_busy_after_2nd", nb, 8);
    check("t3_ena_during", ena_or, 8'h00);
    check("t3_ena", um_ena, 8'h40);
    @(negedge clk);
    check("t3_ow", spine_usr_ow, 24'hC3C3C3);

    // row field mismatch
    pulse(mk_sel(4'h2, 1'b1, 5'd1));
    wait_idle(nb, ena_or, stale);
    check("t4_busy_cycles", nb, 5);
    check("t4_ena", um_ena, 8'h00);
    check("t4_iw", um_iw, '0);
    @(negedge clk);
    check("t4_ow", spine_usr_ow, '0);
    check("t4_vld", spine_ow_vld, 1'b0);

    // N_UM=6 instance, index 7 out of range
    spine_sel6     = mk_sel(4'h1, 1'b1, 5'd7);
    spine_sel_stb6 = 1'b1;
    @(negedge clk);
    spine_sel_stb6 = 1'b0;
    nb = 0;
    busy_seen = 1'b0;
    while (busy6 && nb < 64) begin
      busy_seen = 1'b1;
      nb++;
      @(negedge clk);
    end
    check("t5_busy6_seen", busy_seen, 1'b1);
    check("t5_busy6_cycles", nb, 5);
    check("t5_ena6", um_ena6, 6'h00);
    @(negedge clk);
    check("t5_ow6", spine_usr_ow6, '0);
    check("t5_vld6", spine_ow_vld6, 1'b0);

    // index 1 selected, then spine_ena dropped
    pulse(mk_sel(4'h1, 1'b1, 5'd1));
    wait_idle(nb, ena_or, stale);
    check("t6_ena", um_ena, 8'h02);
    spine_ena = 1'b0;
    #1;
    check("t6_ena_drop", um_ena, 8'h00);
    check("t6_iw_kept", um_iw, iw_at(1));
    spine_ena = 1'b1;
    #1;
    check("t6_ena_back", um_ena, 8'h02);
    @(negedge clk);

    // async reset in GUARD, pending strobe discarded
    pulse(mk_sel(4'h1, 1'b1, 5'd4));
    @(negedge clk);
    check("t7_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_busy_rst", busy, 1'b0);
    check("t7_ena_rst", um_ena, 8'h00);
    check("t7_iw_rst", um_iw, '0);
    check("t7_vld_rst", spine_ow_vld, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    ena_or    = '0;
    repeat (10) begin
      @(negedge clk);
      busy_seen |= busy;
      ena_or    |= um_ena;
    end
    check("t7_busy_after", busy_seen, 1'b0);
    check("t7_ena_after", ena_or, 8'h00);
    check("t7_ow_after", spine_usr_ow, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
